ccu_round_seq: RTL and testbench
================================

Name: ccu_round_seq

Overview:
- Nibble-serial sequencer for the 4-bit `ccu` cipher core.
- Collects a block of NIBBLES data/key nibble pairs from the pin-level input stream and runs ROUNDS passes of every state nibble through the core, one nibble per cycle, with a rotating key-nibble schedule.
- Streams the result nibbles out under valid/ready backpressure.
- Sits between the top-level pin wrapper and the `ccu` instance.

Parameters:
- NIBBLES, 4: nibbles per block and per key; ≥2.
- ROUNDS, 4: rounds per block; ≥1.
- CORE_LAT, 1: cycles from core_din/core_kin presented to core_dout valid; ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data/in_key nibble pair valid.
- in_ready  out  1  sequencer accepts a pair this cycle.
- in_data  in  4  data nibble.
- in_key  in  4  key nibble.
- core_din  out  4  state nibble to core.
- core_kin  out  4  key nibble to core.
- core_dout  in  4  core result, CORE_LAT cycles after issue.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  4  result nibble.
- busy  out  1  high in ISSUE or DRAIN.
- done  out  1  one-cycle pulse on the final output handshake of a block.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - State = LOAD; all counters 0; state/key buffers cleared to 0.
  - out_valid = 0, done = 0, busy = 0, core_din = core_kin = 0.
  - in_ready = 0 while reset is high.
- States: LOAD → ISSUE → DRAIN → (ISSUE | OUT) → LOAD.

LOAD
- in_ready = 1.
- Each in_valid & in_ready cycle writes state[i] = in_data, key[i] = in_key, where i is the load counter (first accepted pair is nibble 0).
- After NIBBLES accepts, go to ISSUE with round r = 0 and n = 0.
- in_valid with in_ready = 0 (any other state) is ignored and never buffered.

ISSUE
- One nibble per cycle, n = 0..NIBBLES-1.
- core_din = state[n]; core_kin = key[(n + r) mod NIBBLES].
- The issue index is carried in a CORE_LAT-deep tag pipeline.
- core_dout is written to state[tag] exactly CORE_LAT cycles after the issue.
- After n = NIBBLES-1, go to DRAIN.
- core_din and core_kin are 0 in every non-ISSUE cycle.

DRAIN
- Lasts exactly CORE_LAT cycles; the last write-back lands in the final DRAIN cycle.
- Then: if r < ROUNDS-1, increment r and go to ISSUE with n = 0; otherwise go to OUT with n = 0.
- Round length is exactly NIBBLES + CORE_LAT cycles.
- Total ISSUE+DRAIN time is ROUNDS × (NIBBLES + CORE_LAT) cycles.

OUT
- out_valid = 1; out_data = state[n].
- Advance n on out_valid & out_ready.
- out_data is held stable while out_ready = 0.
- The handshake on n = NIBBLES-1 asserts done for that same cycle and returns to LOAD with counters cleared.
- in_ready rises the following cycle.

Other rules
- core_dout is sampled only in write-back cycles; all other values are ignored.
- Counters wrap only via explicit clears; no modular overflow is relied upon.
- Reset asserted in any state (mid-load, mid-round, mid-output) aborts the block: no output, no done pulse, buffers cleared, and LOAD is re-entered the cycle after reset deasserts.

Test Plan:
All scenarios use a mock core with core_dout = core_din ^ core_kin, registered once (CORE_LAT = 1).

1. Defaults, full block:
   - Stimulus: load data 1,2,3,4 and key 1,2,4,8 with continuous in_valid and out_ready = 1.
   - Required: in_ready low after the 4th accept; busy high for exactly 20 cycles; outputs E,D,C,B in order; done pulses with B.
2. ROUNDS = 1:
   - Stimulus: same data and key as scenario 1.
   - Required: outputs 0,0,7,C; busy high for exactly 5 cycles.
3. Backpressure:
   - Stimulus: scenario 1 with out_ready low for 3 cycles while D is presented.
   - Required: out_data holds D and out_valid stays 1; sequence completes E,D,C,B; done fires once.
4. Input gaps:
   - Stimulus: in_valid toggles 1,0,1,0,...
   - Required: exactly 4 nibbles captured; result identical to scenario 1.
   - Stimulus: drive in_valid during ISSUE.
   - Required: ignored; in_ready = 0 throughout.
5. Reset mid-round:
   - Stimulus: assert reset for 1 cycle during round 2 ISSUE.
   - Required: next cycle state = LOAD, busy = 0, out_valid = 0, no done; a fresh block afterwards yields correct results.
6. CORE_LAT = 3 with a matching 3-stage mock:
   - Stimulus: data and key as scenario 1.
   - Required: outputs E,D,C,B; busy high for exactly 28 cycles.

Source files
------------

// File: rtl/ccu_round_seq_if.sv
// ccu_round_seq_if - bundle of every non-clock signal of the ccu round sequencer.
//   in_*   : pin-side nibble-pair input stream (valid/ready)
//   core_* : issue/result path to the ccu cipher core
//   out_*  : result nibble stream (valid/ready)
//   busy, done : status
// slave  : the sequencer side.
// master : the surrounding wrapper, which also owns the core result.
interface ccu_round_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] in_key;
    logic [3:0] core_din;
    logic [3:0] core_kin;
    logic [3:0] core_dout;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;
    logic       done;

    modport master (
        output in_valid, in_data, in_key, core_dout, out_ready,
        input  in_ready, core_din, core_kin, out_valid, out_data, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_key, core_dout, out_ready,
        output in_ready, core_din, core_kin, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/ccu_round_seq.sv
// ccu_round_seq - nibble-serial round sequencer for the 4-bit ccu cipher core.
// Loads NIBBLES data/key pairs, runs ROUNDS passes of every state nibble through
// the core (one nibble per cycle, key index rotating by round), then streams
// the state out under valid/ready.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; aborts any block in progress
//   bus   : ccu_round_seq_if.slave (input stream, core path, output stream, busy/done)
module ccu_round_seq #(
    parameter int NIBBLES  = 4,
    parameter int ROUNDS   = 4,
    parameter int CORE_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    ccu_round_seq_if.slave   bus
);
    localparam int NW = (NIBBLES  > 1) ? $clog2(NIBBLES)  : 1;
    localparam int RW = (ROUNDS   > 1) ? $clog2(ROUNDS)   : 1;
    localparam int DW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    localparam logic [NW-1:0] N_LAST = NW'(NIBBLES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROUNDS - 1);
    localparam logic [DW-1:0] D_LAST = DW'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state, state_nx;

    // n_cnt is shared: load index, issue index and output index
    logic [NW-1:0] n_cnt;
    logic [RW-1:0] r_cnt;
    logic [DW-1:0] d_cnt;

    logic [NIBBLES-1:0][3:0] st_buf;
    logic [NIBBLES-1:0][3:0] key_buf;

    // vld_pipe[k]/tag_pipe[k]: a nibble issued k cycles ago; stage CORE_LAT is the write-back
    logic [CORE_LAT:1]         vld_pipe;
    logic [CORE_LAT:1][NW-1:0] tag_pipe;

    logic          issue;
    logic          load_fire;
    logic          out_fire;
    logic          n_last;
    logic [NW-1:0] kidx;

    assign n_last = (n_cnt == N_LAST);
    assign kidx   = NW'((32'(n_cnt) + 32'(r_cnt)) % NIBBLES);

    // Next state and outputs. Everything is forced quiet while reset is high so
    // an aborted block can never leak a valid, busy or done.
    always_comb begin
        state_nx      = state;
        issue         = 1'b0;
        load_fire     = 1'b0;
        out_fire      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 4'h0;
        bus.done      = 1'b0;
        bus.core_din  = 4'h0;
        bus.core_kin  = 4'h0;
        if (!reset) begin
            case (state)
                S_LOAD: begin
                    bus.in_ready = 1'b1;
                    load_fire    = bus.in_valid;
                    if (bus.in_valid && n_last) state_nx = S_ISSUE;
                end
                S_ISSUE: begin
                    bus.busy     = 1'b1;
                    issue        = 1'b1;
                    bus.core_din = st_buf[n_cnt];
                    bus.core_kin = key_buf[kidx];
                    if (n_last) state_nx = S_DRAIN;
                end
                S_DRAIN: begin
                    bus.busy = 1'b1;
                    if (d_cnt == D_LAST) state_nx = (r_cnt == R_LAST) ? S_OUT : S_ISSUE;
                end
                S_OUT: begin
                    bus.out_valid = 1'b1;
                    bus.out_data  = st_buf[n_cnt];
                    if (bus.out_ready) begin
                        out_fire = 1'b1;
                        if (n_last) begin
                            bus.done = 1'b1;
                            state_nx = S_LOAD;
                        end
                    end
                end
                default: state_nx = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_LOAD;
            n_cnt    <= '0;
            r_cnt    <= '0;
            d_cnt    <= '0;
            st_buf   <= '0;
            key_buf  <= '0;
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            state <= state_nx;

            vld_pipe[1] <= issue;
            tag_pipe[1] <= n_cnt;
            for (int k = 2; k <= CORE_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end

            // core_dout is only looked at in a write-back cycle
            if (vld_pipe[CORE_LAT]) st_buf[tag_pipe[CORE_LAT]] <= bus.core_dout;

            case (state)
                S_LOAD: begin
                    if (load_fire) begin
                        st_buf[n_cnt]  <= bus.in_data;
                        key_buf[n_cnt] <= bus.in_key;
                        n_cnt          <= n_last ? '0 : n_cnt + 1'b1;
                    end
                    r_cnt <= '0;
                    d_cnt <= '0;
                end
                S_ISSUE: begin
                    n_cnt <= n_last ? '0 : n_cnt + 1'b1;
                    d_cnt <= '0;
                end
                S_DRAIN: begin
                    if (d_cnt == D_LAST) begin
                        d_cnt <= '0;
                        r_cnt <= (r_cnt == R_LAST) ? '0 : r_cnt + 1'b1;
                    end else begin
                        d_cnt <= d_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_fire) n_cnt <= n_last ? '0 : n_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ccu_round_seq.sv
// tb_ccu_round_seq - three sequencer instances side by side sharing one stimulus
// stream: defaults, ROUNDS=1, and CORE_LAT=3. Each has an XOR mock core with a
// matching latency. A per-instance transaction model predicts every output on
// every cycle; literal results pin the model on the directed blocks.
module tb_ccu_round_seq;
    localparam int NC = 3;
    localparam int N  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] in_data;
    logic [3:0] in_key;

    logic [NC-1:0]      w_in_ready, w_out_valid, w_busy, w_done;
    logic [NC-1:0][3:0] w_out_data, w_core_din, w_core_kin;

    for (genvar g = 0; g < NC; g++) begin : cfg
        localparam int R = (g == 1) ? 1 : 4;
        localparam int L = (g == 2) ? 3 : 1;

        ccu_round_seq_if bus ();
        logic [L-1:0][3:0] mc;

        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.in_key    = in_key;
        assign bus.out_ready = out_ready;
        assign bus.core_dout = mc[L-1];

        always @(posedge clk) begin
            mc[0] <= bus.core_din ^ bus.core_kin;
            for (int k = 1; k < L; k++) mc[k] <= mc[k-1];
        end

        ccu_round_seq #(.NIBBLES(N), .ROUNDS(R), .CORE_LAT(L)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );

        assign w_in_ready[g]  = bus.in_ready;
        assign w_out_valid[g] = bus.out_valid;
        assign w_busy[g]      = bus.busy;
        assign w_done[g]      = bus.done;
        assign w_out_data[g]  = bus.out_data;
        assign w_core_din[g]  = bus.core_din;
        assign w_core_kin[g]  = bus.core_kin;
    end

    int vectors     = 0;
    int miscompares = 0;

    // written by the stimulus process only
    logic pin_blk = 1'b0;
    int   tmo_req = 0;

    // written by the checker process only
    int         tmo_seen = 0;
    int         dcnt [NC];
    int         bcnt [NC];
    int         m_phase [NC];   // 0 loading, 1 rounds running, 2 presenting output
    int         m_ld [NC];
    int         m_t [NC];
    int         m_oi [NC];
    logic [3:0] m_d [NC][N];
    logic [3:0] m_k [NC][N];
    logic [3:0] m_rv [NC][5][N]; // m_rv[c][r] = state entering round r; [ROUNDS] = result
    logic [3:0] obs [NC][N];
    logic [3:0] lit_out [NC][N];
    int         lit_busy [NC];
    int         rr, ll, rl, ri, pi;
    logic       e_ir, e_b, e_ov, e_dn;
    logic [3:0] e_od, e_din, e_kin;

    task automatic chk(input int c, input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL cfg%0d %s t=%0t got %0h want %0h", c, nm, $time, act, exp);
        end
    endtask

    // checker: compare every output of every instance each cycle, then advance the model
    initial begin
        lit_out[0] = '{4'hE, 4'hD, 4'hC, 4'hB};
        lit_out[1] = '{4'h0, 4'h0, 4'h7, 4'hC};
        lit_out[2] = '{4'hE, 4'hD, 4'hC, 4'hB};
        lit_busy   = '{20, 5, 28};
        for (int c = 0; c < NC; c++) begin
            m_phase[c] = 0; m_ld[c] = 0; m_t[c] = 0; m_oi[c] = 0;
            dcnt[c] = 0; bcnt[c] = 0;
        end
        forever begin
            @(negedge clk);
            vectors++;
            if (tmo_req != tmo_seen) begin
                miscompares++;
                $display("FAIL block_timeout t=%0t got %0d expired waits want 0", $time, tmo_req - tmo_seen);
                tmo_seen = tmo_req;
            end
            for (int c = 0; c < NC; c++) begin
                rr = (c == 1) ? 1 : 4;
                ll = (c == 2) ? 3 : 1;
                rl = N + ll;
                e_ir = !reset && m_phase[c] == 0;
                e_b  = !reset && m_phase[c] == 1;
                e_ov = !reset && m_phase[c] == 2;
                e_od = e_ov ? m_rv[c][rr][m_oi[c]] : 4'h0;
                e_dn = e_ov && out_ready && m_oi[c] == N - 1;
                e_din = 4'h0;
                e_kin = 4'h0;
                if (e_b) begin
                    ri = m_t[c] / rl;
                    pi = m_t[c] % rl;
                    if (pi < N) begin
                        e_din = m_rv[c][ri][pi];
                        e_kin = m_k[c][(pi + ri) % N];
                    end
                end
                chk(c, "in_ready",  32'(w_in_ready[c]),  32'(e_ir));
                chk(c, "busy",      32'(w_busy[c]),      32'(e_b));
                chk(c, "out_valid", 32'(w_out_valid[c]), 32'(e_ov));
                chk(c, "out_data",  32'(w_out_data[c]),  32'(e_od));
                chk(c, "done",      32'(w_done[c]),      32'(e_dn));
                chk(c, "core_din",  32'(w_core_din[c]),  32'(e_din));
                chk(c, "core_kin",  32'(w_core_kin[c]),  32'(e_kin));

                if (w_busy[c] === 1'b1) bcnt[c]++;
                if (w_done[c] === 1'b1) dcnt[c]++;

                if (reset) begin
                    m_phase[c] = 0; m_ld[c] = 0; m_t[c] = 0; m_oi[c] = 0;
                end else begin
                    case (m_phase[c])
                        0: if (in_valid) begin
                            m_d[c][m_ld[c]] = in_data;
                            m_k[c][m_ld[c]] = in_key;
                            m_ld[c]++;
                            if (m_ld[c] == N) begin
                                for (int n = 0; n < N; n++) m_rv[c][0][n] = m_d[c][n];
                                for (int r = 0; r < rr; r++)
                                    for (int n = 0; n < N; n++)
                                        m_rv[c][r+1][n] = m_rv[c][r][n] ^ m_k[c][(n + r) % N];
                                m_phase[c] = 1; m_t[c] = 0; bcnt[c] = 0;
                            end
                        end
                        1: begin
                            m_t[c]++;
                            if (m_t[c] == rr * rl) begin
                                m_phase[c] = 2; m_oi[c] = 0;
                            end
                        end
                        default: if (out_ready) begin
                            obs[c][m_oi[c]] = w_out_data[c];
                            if (m_oi[c] == N - 1) begin
                                if (pin_blk) begin
                                    for (int n = 0; n < N; n++)
                                        chk(c, "pinned_result", 32'(obs[c][n]), 32'(lit_out[c][n]));
                                    chk(c, "pinned_busy_len", 32'(bcnt[c]), 32'(lit_busy[c]));
                                end
                                m_phase[c] = 0; m_ld[c] = 0;
                            end else begin
                                m_oi[c]++;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // load data 1,2,3,4 / key 1,2,4,8, optionally with a bubble after every pair,
    // then keep in_valid up with junk for a few cycles while the rounds run
    task automatic load_block(input logic gaps);
        logic [3:0] dd [N];
        logic [3:0] kk [N];
        dd = '{4'h1, 4'h2, 4'h3, 4'h4};
        kk = '{4'h1, 4'h2, 4'h4, 4'h8};
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1; in_data = dd[i]; in_key = kk[i];
            @(posedge clk); #1;
            if (gaps && i < N - 1) begin
                in_valid = 1'b0; in_data = 4'hF; in_key = 4'hF;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1; in_data = 4'hA; in_key = 4'h5;
        repeat (4) begin @(posedge clk); #1; end
        in_valid = 1'b0;
    endtask

    // wait until every instance has signalled done once more; bp stalls instance 0 on D
    task automatic wait_done_all(input logic bp);
        int   base [NC];
        int   bp_left;
        logic ok;
        base    = dcnt;
        bp_left = 3;
        ok      = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            ok = 1'b1;
            for (int c = 0; c < NC; c++) if (dcnt[c] == base[c]) ok = 1'b0;
            if (!ok) begin
                if (bp && bp_left > 0 && w_out_valid[0] && w_out_data[0] == 4'hD) begin
                    out_ready = 1'b0;
                    bp_left--;
                end else begin
                    out_ready = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        if (!ok) tmo_req++;
    endtask

    task automatic pinned_block(input logic gaps, input logic bp);
        pin_blk = 1'b1;
        load_block(gaps);
        wait_done_all(bp);
        pin_blk = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_key = 4'h0; out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;

        pinned_block(1'b0, 1'b0);
        pinned_block(1'b0, 1'b1);
        pinned_block(1'b1, 1'b0);

        // abort in the middle of the second round of the default instance
        in_valid = 1'b1; in_data = 4'h9; in_key = 4'h3;
        repeat (N) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        pinned_block(1'b0, 1'b0);

        for (int i = 0; i < 2500; i++) begin
            reset     = ($urandom_range(0, 399) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = 4'($urandom);
            in_key    = 4'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
